// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: serial UART transmitter with its own 16x sample-tick divider.
// Sends a start/data/stop frame LSB first on an idle-high line; each bit
// lasts 16 sample ticks so the line stays baud-matched to the receiver.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low
//   tx_data   word to send, sampled on accept
//   tx_valid  tx_data is valid
//   tx_ready  idle, can accept a word (registered)
//   tx        serial line, idle high (registered)
//   tx_busy   frame in progress (registered)
//   tx_done   one-cycle pulse at the end of the stop bit (registered)
//
// Build option: define UART_TX_PARITY_EN to send an even-parity bit
// between the last data bit and the stop bit.
module uart_tx #(
    parameter int unsigned TICK_DIV  = 54,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned SB_TICKS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCNT_W = 6;
    localparam int unsigned NCNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                r_state;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [SCNT_W-1:0]     r_s_cnt;
    logic [NCNT_W-1:0]     r_n_cnt;
    logic [DATA_BITS-1:0]  r_shreg;
    logic                  r_tx;
    logic                  r_tx_ready;
    logic                  r_tx_busy;
    logic                  r_tx_done;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic w_s_tick;
    logic w_accept;
    logic w_bit_end;

    assign w_s_tick  = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_accept  = tx_valid && r_tx_ready;
    // 16th tick of a 16-tick bit (start, data, parity)
    assign w_bit_end = w_s_tick && (r_s_cnt == SCNT_W'(15));

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign tx_busy  = r_tx_busy;
    assign tx_done  = r_tx_done;

    // Sample-tick divider; restarts on accept so the start bit is full length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_accept || w_s_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Frame FSM; tx and status outputs are set on the transition edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_s_cnt    <= '0;
            r_n_cnt    <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_START;
                        r_shreg    <= tx_data;
                        r_s_cnt    <= '0;
                        r_n_cnt    <= '0;
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^tx_data;
`endif
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_s_cnt <= '0;
                        r_n_cnt <= '0;
                        r_tx    <= r_shreg[0];
                    end else if (w_s_tick) begin
                        r_s_cnt <= r_s_cnt + SCNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_shreg <= r_shreg >> 1;
                        r_s_cnt <= '0;
                        if (r_n_cnt == NCNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_n_cnt <= r_n_cnt + NCNT_W'(1);
                            // next bit is the one about to shift into [0]
                            r_tx    <= r_shreg[1];
                        end
                    end else if (w_s_tick) begin
                        r_s_cnt <= r_s_cnt + SCNT_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_s_cnt <= '0;
                        r_tx    <= 1'b1;
                    end else if (w_s_tick) begin
                        r_s_cnt <= r_s_cnt + SCNT_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (w_s_tick && (r_s_cnt == SCNT_W'(SB_TICKS - 1))) begin
                        r_state    <= ST_IDLE;
                        r_s_cnt    <= '0;
                        r_tx       <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_tx_busy  <= 1'b0;
                        r_tx_done  <= 1'b1;
                    end else if (w_s_tick) begin
                        r_s_cnt <= r_s_cnt + SCNT_W'(1);
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_s_cnt    <= '0;
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx: scoreboard bench for uart_tx. Two instances at TICK_DIV=4:
// u0 = 8 data bits / 1 stop bit, u1 = 5 data bits / 2 stop bits.
// Stimulus pushes expected words; a per-instance monitor decodes each
// frame on tx and compares bit values, timing and status outputs.
module tb_uart_tx;

    localparam int unsigned TD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data  [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic       tx_s     [2];
    logic       tx_busy  [2];
    logic       tx_done  [2];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned DB = (g == 0) ? 8 : 5;
        localparam int unsigned SB = (g == 0) ? 16 : 32;
        uart_tx #(.TICK_DIV(TD), .DATA_BITS(DB), .SB_TICKS(SB)) u_dut (
            .clk      (clk),
            .reset    (rst_n),
            .tx_data  (tx_data[g][DB-1:0]),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .tx       (tx_s[g]),
            .tx_busy  (tx_busy[g]),
            .tx_done  (tx_done[g])
        );
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic void sb_push(input int g, input logic [7:0] d, input bit b2b);
        exp_t e;
        e.data = d;
        e.b2b  = b2b;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic bit sb_pop(input int g, output exp_t e);
        e.data = '0;
        e.b2b  = 1'b0;
        if (g == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1.pop_front();
        end
        return 1'b1;
    endfunction

    // Frame decoder and checker for instance g.
    task automatic mon(input int g);
        int         db, sb, nbits, f, k, last_start, bi;
        logic       prev, expb, par, bad;
        logic [7:0] d, mask;
        bit         abort;
        exp_t       e;
        db    = (g == 0) ? 8 : 5;
        sb    = (g == 0) ? 16 : 32;
        nbits = 1 + db + PB;
        f     = (nbits * 16 + sb) * TD;
        mask  = 8'((1 << db) - 1);
        prev  = 1'b1;
        last_start = -100000;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !tx_s[g]) begin
                k = cyc;
                if (!sb_pop(g, e)) begin
                    chk($sformatf("u%0d_unexpected_frame", g), {31'b0, tx_s[g]}, 32'd1);
                end else begin
                    if (e.b2b) chk($sformatf("u%0d_b2b_gap", g), 32'(k - last_start), 32'(f + 1));
                    d     = e.data & mask;
                    par   = ^d;
                    bad   = 1'b0;
                    abort = 1'b0;
                    for (int c = 0; c < f; c++) begin
                        if (c > 0) begin
                            @(posedge clk); #1;
                        end
                        if (!rst_n) begin
                            abort = 1'b1;
                            break;
                        end
                        bi = c / (16 * TD);
                        if (bi == 0)          expb = 1'b0;
                        else if (bi <= db)    expb = d[bi-1];
                        else if (bi < nbits)  expb = par;
                        else                  expb = 1'b1;
                        if (tx_s[g] !== expb || tx_ready[g] !== 1'b0 ||
                            tx_busy[g] !== 1'b1 || tx_done[g] !== 1'b0) bad = 1'b1;
                        if (bi < nbits && (c % (16 * TD)) == 8 * TD)
                            chk($sformatf("u%0d_d%02h_bit%0d", g, d, bi), {31'b0, tx_s[g]}, {31'b0, expb});
                        if (c == nbits * 16 * TD + (sb * TD) / 2)
                            chk($sformatf("u%0d_d%02h_stop", g, d), {31'b0, tx_s[g]}, 32'd1);
                    end
                    if (!abort) begin
                        chk($sformatf("u%0d_d%02h_frame_steady", g, d), {31'b0, bad}, 32'd0);
                        @(posedge clk); #1;
                        if (rst_n) begin
                            // after edge k+F: tx, ready, busy, done
                            chk($sformatf("u%0d_d%02h_end_status", g, d),
                                {28'b0, tx_s[g], tx_ready[g], tx_busy[g], tx_done[g]}, 32'b1101);
                        end
                        last_start = k;
                    end
                end
            end
            prev = tx_s[g];
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
        join_none
    end

    // Offer a single word on instance g once it is ready.
    task automatic send(input int g, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready[g] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready[g]) chk($sformatf("u%0d_ready_timeout", g), {31'b0, tx_ready[g]}, 32'd1);
        tx_data[g]  = d;
        tx_valid[g] = 1'b1;
        sb_push(g, d, 1'b0);
        @(negedge clk);
        tx_valid[g] = 1'b0;
    endtask

    initial begin
        int  n;
        logic bad0, bad1;
        tx_valid[0] = 1'b0;
        tx_valid[1] = 1'b0;
        tx_data[0]  = 8'h00;
        tx_data[1]  = 8'h00;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("u0_reset_status", {28'b0, tx_s[0], tx_ready[0], tx_busy[0], tx_done[0]}, 32'b1100);
        chk("u1_reset_status", {28'b0, tx_s[1], tx_ready[1], tx_busy[1], tx_done[1]}, 32'b1100);
        @(negedge clk);
        rst_n = 1'b1;

        // Quiet line after reset with nothing offered.
        bad0 = 1'b0;
        bad1 = 1'b0;
        repeat (1000) begin
            @(posedge clk); #1;
            if ({tx_s[0], tx_ready[0], tx_busy[0], tx_done[0]} !== 4'b1100) bad0 = 1'b1;
            if ({tx_s[1], tx_ready[1], tx_busy[1], tx_done[1]} !== 4'b1100) bad1 = 1'b1;
        end
        chk("u0_idle_1000", {31'b0, bad0}, 32'd0);
        chk("u1_idle_1000", {31'b0, bad1}, 32'd0);

        fork
            send(0, 8'hA5);
            send(1, 8'h15);
        join
        send(0, 8'h07);

        // Back-to-back with tx_valid held, tx_data disturbed mid-frame.
        n = 0;
        @(negedge clk);
        while (!tx_ready[0] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tx_data[0]  = 8'h00;
        tx_valid[0] = 1'b1;
        sb_push(0, 8'h00, 1'b0);
        sb_push(0, 8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        tx_data[0] = 8'h5A;
        repeat (300) @(negedge clk);
        tx_data[0] = 8'hFF;
        n = 0;
        while (!tx_ready[0] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("u0_b2b_ready_return", {31'b0, tx_ready[0]}, 32'd1);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        tx_data[0]  = 8'h5A;
        repeat (200) @(negedge clk);
        tx_data[0]  = 8'h81;

        // Abort a frame during bit 3, then send a clean one.
        send(0, 8'hC3);
        repeat (3 * 16 * TD + 30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("u0_async_reset", {28'b0, tx_s[0], tx_ready[0], tx_busy[0], tx_done[0]}, 32'b1100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h3C);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || tx_busy[0] || tx_busy[1]) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the communication module, the transmit-side counterpart of the receive path and its 16x sample-tick generator. Accepts one data word over a valid/ready handshake and shifts it out on `tx` as an idle-high, start/data/stop frame, LSB first. Contains its own sample-tick divider, so every bit is timed as 16 sample ticks, which keeps it baud-matched to the receiver.

## Interface
- `TICK_DIV`, default 54: clocks per sample tick (≥2); one bit = 16 ticks = 16*TICK_DIV clocks.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `SB_TICKS`, default 16: stop-bit length in ticks; 16, 24 or 32 gives 1, 1.5 or 2 stop bits.

- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low.
- `tx_data` input DATA_BITS: word to send; sampled only on accept.
- `tx_valid` input 1: word on `tx_data` is valid.
- `tx_ready` output 1: block in IDLE, can accept a word. Reset value 1.
- `tx` output 1: serial line. Reset value 1 (idle/mark).
- `tx_busy` output 1: frame in progress (not IDLE). Reset value 0.
- `tx_done` output 1: one-cycle pulse at end of the stop bit. Reset value 0.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Tick divider: `tick_cnt` counts 0..TICK_DIV-1, width $clog2(TICK_DIV); internal `s_tick` is high for one clock when `tick_cnt`==TICK_DIV-1, and the counter wraps to 0 on that clock. The counter clears to 0 on accept, so the first bit has full length.
- Sample counter `s_cnt`, 6 bits, counts ticks within the current bit and clears on every state change. Bit counter `n_cnt`, 3 bits. Shift register `shreg`, DATA_BITS wide.
- IDLE: `tx`=1, `tx_ready`=1. Accept = `tx_valid`&&`tx_ready` at a rising edge. On accept: `shreg`<=`tx_data`, go to START, `tx`<=0.
- START: `tx`=0. On the 16th tick (`s_cnt`==15 && `s_tick`), go to DATA with `n_cnt`=0.
- DATA: `tx`=`shreg[0]`. On the 16th tick, shift `shreg` right. If `n_cnt`==DATA_BITS-1, go to PARITY (or to STOP without the macro); otherwise increment `n_cnt`.
- PARITY: `tx`=even parity (XOR of all data bits, computed on accept). Lasts 16 ticks, then goes to STOP.
- STOP: `tx`=1. On tick `s_cnt`==SB_TICKS-1, go to IDLE and pulse `tx_done`.
- `tx` is registered and glitch-free. `tx_data`/`tx_valid` changes while busy are ignored.
- Reset asserted mid-frame aborts immediately: outputs return to reset values and all counters go to 0. No partial frame resumes.

## Timing
- Accept at edge k: `tx` falls, `tx_ready` falls and `tx_busy` rises after edge k. The start bit begins on that cycle.
- Bit i (start = 0) begins after edge k + i*16*TICK_DIV.
- Frame length F = ((1+DATA_BITS+P)*16 + SB_TICKS)*TICK_DIV clocks, where P=1 with parity.
- After edge k+F: state is IDLE, `tx_ready`=1, `tx_busy`=0, and `tx_done`=1 for exactly that one cycle.
- Back-to-back: with `tx_valid` held high, the next accept happens at edge k+F+1. There is no extra idle time beyond the stop bit, plus one clock.
- Latency from valid (while ready) to the start-bit edge: 1 clock.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and an even-parity bit is sent between the last data bit and stop, so the frame is 16 ticks longer.
- Not defined: the PARITY state and the parity logic are absent, and DATA goes directly to STOP.

## Test plan
- Reset: hold `reset`=0, then release. Required: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, no activity for 1000 clocks.
- Single frame: TICK_DIV=4, 0xA5, no parity. Required: 64 clocks per bit on `tx`, sequence 0,1,0,1,0,0,1,0,1,1; `tx_done` at accept+640; `tx_ready` low for 640 cycles.
- Parity build: 0xA5 gives parity bit 0, and 0x07 gives parity bit 1. Required: frame of 704 clocks.
- Back-to-back: 0x00 then 0xFF with `tx_valid` held high. Required: second start bit begins exactly 641 clocks after the first; `tx_data` changes mid-frame do not corrupt the frame.
- Stop length: SB_TICKS=32. Required: stop high for 128 clocks and frame 704 clocks (no parity). DATA_BITS=5 with 0x15: 5 data bits only.
- Reset mid-frame: assert `reset` during bit 3. Required: `tx`=1 and `tx_ready`=1 asynchronously. After release, a new 0x3C frame is sent correctly.
